// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit: one read or write bus transaction per request
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lsu_start_i,
    input  logic                  lsu_store_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_done_o,
    output logic                  lsu_error_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  dr_addr_valid_o,
    input  logic                  dr_addr_ready_i,
    output logic [ADDR_WIDTH-1:0] dr_addr_o,
    input  logic                  dr_data_valid_i,
    output logic                  dr_data_ready_o,
    input  logic [DATA_WIDTH-1:0] dr_data_i,
    output logic                  dw_req_valid_o,
    input  logic                  dw_req_ready_i,
    output logic [ADDR_WIDTH-1:0] dw_addr_o,
    output logic [DATA_WIDTH-1:0] dw_data_o,
    output logic [3:0]            dw_strobe_o,
    input  logic                  dw_resp_valid_i,
    output logic                  dw_resp_ready_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
    } state_t;

    state_t                  state_q;
    logic [1:0]              addr_lo_q;
    logic [2:0]              funct3_q;
    logic                    busy_q, done_q, error_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    dr_addr_valid_q, dr_data_ready_q;
    logic [ADDR_WIDTH-1:0]   dr_addr_q, dw_addr_q;
    logic                    dw_req_valid_q, dw_resp_ready_q;
    logic [DATA_WIDTH-1:0]   dw_data_q;
    logic [3:0]              dw_strobe_q;

    logic                    req_bad;
    logic                    legal_ld, legal_st, misaligned;
    logic [DATA_WIDTH-1:0]   st_data;
    logic [3:0]              st_strobe;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_data;

    // Request legality and store lane placement, evaluated on the live inputs at the start edge.
    always_comb begin
        legal_ld   = 1'b0;
        legal_st   = 1'b0;
        misaligned = 1'b0;
        st_data    = lsu_wdata_i;
        st_strobe  = 4'b1111;
        case (lsu_funct3_i)
            3'b000: begin legal_ld = 1'b1; legal_st = 1'b1; end
            3'b001: begin legal_ld = 1'b1; legal_st = 1'b1; misaligned = lsu_addr_i[0]; end
            3'b010: begin legal_ld = 1'b1; legal_st = 1'b1; misaligned = |lsu_addr_i[1:0]; end
            3'b100: legal_ld = 1'b1;
            3'b101: begin legal_ld = 1'b1; misaligned = lsu_addr_i[0]; end
            default: ;
        endcase
        req_bad = (lsu_store_i ? !legal_st : !legal_ld) | misaligned;
        case (lsu_funct3_i[1:0])
            2'b00: begin
                st_data   = {4{lsu_wdata_i[7:0]}};
                st_strobe = 4'b0001 << lsu_addr_i[1:0];
            end
            2'b01: begin
                st_data   = {2{lsu_wdata_i[15:0]}};
                st_strobe = 4'b0011 << {lsu_addr_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dr_data_i[{addr_lo_q, 3'b000} +: 8];
        ld_half = dr_data_i[{addr_lo_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dr_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            addr_lo_q       <= '0;
            funct3_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            rdata_q         <= '0;
            dr_addr_valid_q <= 1'b0;
            dr_addr_q       <= '0;
            dr_data_ready_q <= 1'b0;
            dw_req_valid_q  <= 1'b0;
            dw_addr_q       <= '0;
            dw_data_q       <= '0;
            dw_strobe_q     <= '0;
            dw_resp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (lsu_start_i) begin
                    addr_lo_q <= lsu_addr_i[1:0];
                    funct3_q  <= lsu_funct3_i;
                    busy_q    <= 1'b1;
                    if (req_bad) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else if (lsu_store_i) begin
                        state_q        <= S_WR_REQ;
                        dw_req_valid_q <= 1'b1;
                        dw_addr_q      <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        dw_data_q      <= st_data;
                        dw_strobe_q    <= st_strobe;
                    end else begin
                        state_q         <= S_RD_ADDR;
                        dr_addr_valid_q <= 1'b1;
                        dr_addr_q       <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
                S_RD_ADDR: if (dr_addr_ready_i) begin
                    state_q         <= S_RD_DATA;
                    dr_addr_valid_q <= 1'b0;
                    dr_data_ready_q <= 1'b1;
                end
                S_RD_DATA: if (dr_data_valid_i) begin
                    state_q         <= S_DONE;
                    dr_data_ready_q <= 1'b0;
                    rdata_q         <= ld_data;
                    done_q          <= 1'b1;
                end
                S_WR_REQ: if (dw_req_ready_i) begin
                    state_q         <= S_WR_RESP;
                    dw_req_valid_q  <= 1'b0;
                    dw_resp_ready_q <= 1'b1;
                end
                S_WR_RESP: if (dw_resp_valid_i) begin
                    state_q         <= S_DONE;
                    dw_resp_ready_q <= 1'b0;
                    done_q          <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy_o      = busy_q;
    assign lsu_done_o      = done_q;
    assign lsu_error_o     = error_q;
    assign lsu_rdata_o     = rdata_q;
    assign dr_addr_valid_o = dr_addr_valid_q;
    assign dr_addr_o       = dr_addr_q;
    assign dr_data_ready_o = dr_data_ready_q;
    assign dw_req_valid_o  = dw_req_valid_q;
    assign dw_addr_o       = dw_addr_q;
    assign dw_data_o       = dw_data_q;
    assign dw_strobe_o     = dw_strobe_q;
    assign dw_resp_ready_o = dw_resp_ready_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, store;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [31:0] dr_addr, dr_data;
    logic        dw_req_valid, dw_req_ready, dw_resp_valid, dw_resp_ready;
    logic [31:0] dw_addr, dw_data;
    logic [3:0]  dw_strobe;

    int tests = 0;
    int fails = 0;
    int rd_valid_cyc = 0, wr_valid_cyc = 0, done_cyc = 0, rd_hs = 0, wr_hs = 0;
    logic [31:0] rd_hs_addr = '0, wr_hs_addr = '0, wr_hs_data = '0;
    logic [3:0]  wr_hs_strb = '0;
    int lat, snap_rv, snap_wv, snap_done, snap_rhs;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_start_i(start), .lsu_store_i(store), .lsu_funct3_i(f3),
        .lsu_addr_i(addr), .lsu_wdata_i(wdata),
        .lsu_busy_o(busy), .lsu_done_o(done), .lsu_error_o(err), .lsu_rdata_o(rdata),
        .dr_addr_valid_o(dr_addr_valid), .dr_addr_ready_i(dr_addr_ready), .dr_addr_o(dr_addr),
        .dr_data_valid_i(dr_data_valid), .dr_data_ready_o(dr_data_ready), .dr_data_i(dr_data),
        .dw_req_valid_o(dw_req_valid), .dw_req_ready_i(dw_req_ready),
        .dw_addr_o(dw_addr), .dw_data_o(dw_data), .dw_strobe_o(dw_strobe),
        .dw_resp_valid_i(dw_resp_valid), .dw_resp_ready_o(dw_resp_ready)
    );

    always @(negedge clk) begin
        if (dr_addr_valid) rd_valid_cyc <= rd_valid_cyc + 1;
        if (dw_req_valid)  wr_valid_cyc <= wr_valid_cyc + 1;
        if (done)          done_cyc     <= done_cyc + 1;
        if (dr_addr_valid && dr_addr_ready) begin
            rd_hs      <= rd_hs + 1;
            rd_hs_addr <= dr_addr;
        end
        if (dw_req_valid && dw_req_ready) begin
            wr_hs      <= wr_hs + 1;
            wr_hs_addr <= dw_addr;
            wr_hs_data <= dw_data;
            wr_hs_strb <= dw_strobe;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
        start = 1'b1; store = st; f3 = fn; addr = a; wdata = wd;
        tick();
        start = 1'b0; addr = 32'hDEAD_BEE0; wdata = 32'h5555_5555; f3 = 3'b111;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic op(input logic st, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                      output int n);
        issue(st, fn, a, wd);
        wait_done(n);
    endtask

    task automatic idle_check(input string tag);
        tick();
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; store = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
        dr_addr_ready = 1'b1; dr_data_valid = 1'b1; dr_data = '0;
        dw_req_ready = 1'b1; dw_resp_valid = 1'b1;
        repeat (2) tick();
        chk("rst_ctrl", {24'd0, busy, done, err, dr_addr_valid, dr_data_ready, dw_req_valid, dw_resp_ready, 1'b0}, 32'd0);
        chk("rst_strobe", {28'd0, dw_strobe}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addrs", dr_addr | dw_addr | dw_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // LB with byte lane 3, zero-wait bus
        dr_data = 32'h80FF_0000;
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        chk("lb_dr_addr", dr_addr, 32'h0000_0100);
        chk("lb_dr_valid", {31'd0, dr_addr_valid}, 32'd1);
        wait_done(lat);
        chk("lb_latency", lat, 2);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_error", {31'd0, err}, 32'd0);
        idle_check("lb");

        dr_data = 32'hBEEF_1234;
        op(1'b0, 3'b101, 32'h0000_0202, 32'h0, lat);
        chk("lhu_rdata", rdata, 32'h0000_BEEF);
        idle_check("lhu");
        op(1'b0, 3'b001, 32'h0000_0202, 32'h0, lat);
        chk("lh_rdata", rdata, 32'hFFFF_BEEF);
        idle_check("lh");
        op(1'b0, 3'b001, 32'h0000_0200, 32'h0, lat);
        chk("lh_lo_rdata", rdata, 32'h0000_1234);
        idle_check("lh_lo");
        dr_data = 32'hCAFE_F00D;
        op(1'b0, 3'b010, 32'h0000_0400, 32'h0, lat);
        chk("lw_rdata", rdata, 32'hCAFE_F00D);
        idle_check("lw");
        dr_data = 32'h80FF_0000;
        op(1'b0, 3'b100, 32'h0000_0102, 32'h0, lat);
        chk("lbu_rdata", rdata, 32'h0000_00FF);
        idle_check("lbu");

        // Stores: lane placement, strobes, load result untouched
        op(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56AB, lat);
        chk("sb_latency", lat, 2);
        chk("sb_addr", wr_hs_addr, 32'h0000_0300);
        chk("sb_strobe", {28'd0, wr_hs_strb}, 32'h2);
        chk("sb_data", wr_hs_data, 32'hABAB_ABAB);
        chk("sb_rdata_kept", rdata, 32'h0000_00FF);
        idle_check("sb");
        op(1'b1, 3'b010, 32'h0000_0304, 32'h1122_3344, lat);
        chk("sw_addr", wr_hs_addr, 32'h0000_0304);
        chk("sw_strobe", {28'd0, wr_hs_strb}, 32'hF);
        chk("sw_data", wr_hs_data, 32'h1122_3344);
        idle_check("sw");
        op(1'b1, 3'b001, 32'h0000_0306, 32'h0000_BEEF, lat);
        chk("sh_strobe", {28'd0, wr_hs_strb}, 32'hC);
        chk("sh_data", wr_hs_data, 32'hBEEF_BEEF);
        idle_check("sh");

        // Rejected requests: done+error after one edge, no bus traffic
        snap_rv = rd_valid_cyc; snap_wv = wr_valid_cyc;
        op(1'b0, 3'b010, 32'h0000_0402, 32'h0, lat);
        chk("lw_mis_latency", lat, 0);
        chk("lw_mis_error", {31'd0, err}, 32'd1);
        idle_check("lw_mis");
        op(1'b0, 3'b011, 32'h0000_0400, 32'h0, lat);
        chk("f3_011_error", {31'd0, err & done}, 32'd1);
        idle_check("f3_011");
        op(1'b1, 3'b100, 32'h0000_0400, 32'h0, lat);
        chk("sbu_illegal_error", {31'd0, err & done}, 32'd1);
        idle_check("sbu");
        op(1'b1, 3'b001, 32'h0000_0301, 32'h0, lat);
        chk("sh_mis_error", {31'd0, err & done}, 32'd1);
        idle_check("sh_mis");
        chk("err_no_rd_valid", rd_valid_cyc - snap_rv, 0);
        chk("err_no_wr_valid", wr_valid_cyc - snap_wv, 0);
        chk("err_rdata_kept", rdata, 32'h0000_00FF);

        // Backpressure on both read channels, start pulses while busy
        snap_done = done_cyc; snap_rhs = rd_hs; snap_wv = wr_valid_cyc;
        dr_addr_ready = 1'b0; dr_data_valid = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; store = 1'b1; f3 = 3'b010; addr = 32'h0000_0600;
            tick();
            chk("bp_addr_stable", dr_addr, 32'h0000_0500);
            chk("bp_valid_held", {31'd0, dr_addr_valid & busy}, 32'd1);
        end
        start = 1'b0;
        dr_addr_ready = 1'b1;
        tick();
        dr_addr_ready = 1'b0;
        chk("bp_data_ready", {31'd0, dr_data_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_wait_busy", {30'd0, busy, done}, 32'd2);
        end
        dr_data = 32'h1122_3344; dr_data_valid = 1'b1;
        wait_done(lat);
        chk("bp_latency", lat, 1);
        chk("bp_rdata", rdata, 32'h1122_3344);
        idle_check("bp");
        repeat (3) tick();
        chk("bp_single_done", done_cyc - snap_done, 1);
        chk("bp_single_rd_hs", rd_hs - snap_rhs, 1);
        chk("bp_no_queued_store", wr_valid_cyc - snap_wv, 0);
        dr_addr_ready = 1'b1;

        // Asynchronous reset mid-read, then a clean store
        dr_data_valid = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0700, 32'h0);
        tick();
        chk("ar_in_rd_data", {31'd0, dr_data_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ctrl", {25'd0, busy, done, err, dr_addr_valid, dr_data_ready, dw_req_valid, dw_resp_ready}, 32'd0);
        chk("ar_rdata", rdata, 32'd0);
        chk("ar_addr", dr_addr, 32'd0);
        #3 rst_n = 1'b1;
        dr_data_valid = 1'b1;
        tick();
        chk("ar_idle_after", {31'd0, busy}, 32'd0);
        op(1'b1, 3'b010, 32'h0000_0800, 32'hDEAD_BEEF, lat);
        chk("ar_sw_latency", lat, 2);
        chk("ar_sw_error", {31'd0, err}, 32'd0);
        chk("ar_sw_addr", wr_hs_addr, 32'h0000_0800);
        chk("ar_sw_data", wr_hs_data, 32'hDEAD_BEEF);
        chk("ar_sw_strobe", {28'd0, wr_hs_strb}, 32'hF);
        idle_check("ar_sw");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
